// File: rtl/shift_pkg.sv
// Shared definitions for the sequential left-shift unit: mode encodings,
// FSM state type and the width of the shift-count field.
package shift_pkg;

    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        SHL_LOGIC = 2'b00,  // fill with 0
        SHL_ROT   = 2'b01,  // fill with the bit shifted out
        SHL_CARRY = 2'b10,  // fill with the previous carry
        SHL_FILL  = 2'b11   // replicate the current lsb
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_left_step.sv
// Single-bit left shift: the fill bit entering the lsb depends on the mode,
// and the bit leaving the msb becomes the new carry.
module shift_left_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             carry,
    input  mode_t            mode,
    output logic [WIDTH-1:0] shifted,
    output logic             carry_out
);

    logic fill;

    // Select the fill bit for the vacated lsb and form the shifted word.
    always_comb begin
        fill = 1'b0;
        case (mode)
            SHL_LOGIC: fill = 1'b0;
            SHL_ROT:   fill = value[WIDTH-1];
            SHL_CARRY: fill = carry;
            SHL_FILL:  fill = value[0];
            default:   fill = 1'b0;
        endcase
        shifted   = {value[WIDTH-2:0], fill};
        carry_out = value[WIDTH-1];
    end

endmodule

// File: rtl/shift_left_seq_unit.sv
// Sequential left-shift unit: loads an operand on start, performs one
// single-bit shift per clock for the requested count, then pulses done.
//
// Handshake: start is a request that is accepted only on a rising edge where
// the FSM is in IDLE; x, cin, {sel1,sel0} and count are captured on that same
// edge. start seen in SHIFT or DONE is dropped. busy is high for the shift
// cycles, done is a single-cycle completion pulse, and the two never overlap.
// The state output exposes the FSM for observation.
module shift_left_seq_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic               cin,
    input  logic               sel1,
    input  logic               sel0,
    input  logic [COUNT_W-1:0] count,
    output logic [WIDTH-1:0]   f,
    output logic               cout,
    output logic               busy,
    output logic               done,
    output state_t             state
);

    state_t             state_q;
    state_t             state_d;
    mode_t              mode_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   f_q;
    logic               cout_q;
    logic [WIDTH-1:0]   step_f;
    logic               step_c;
    logic               accept;

    assign accept = (state_q == IDLE) && start;

    shift_left_step #(.WIDTH(WIDTH)) u_step (
        .value     (f_q),
        .carry     (cout_q),
        .mode      (mode_q),
        .shifted   (step_f),
        .carry_out (step_c)
    );

    // FSM state register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero count skips SHIFT, the last shift lands in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == COUNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accepted start, shift once per SHIFT cycle, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= '0;
            cout_q <= 1'b0;
            mode_q <= SHL_LOGIC;
            cnt_q  <= '0;
        end else if (accept) begin
            f_q    <= x;
            cout_q <= cin;
            mode_q <= mode_t'({sel1, sel0});
            cnt_q  <= count;
        end else if (state_q == SHIFT) begin
            f_q    <= step_f;
            cout_q <= step_c;
            cnt_q  <= cnt_q - COUNT_W'(1);
        end
    end

    assign f     = f_q;
    assign cout  = cout_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign state = state_q;

endmodule

// File: tb/tb_shift_left_seq_unit.sv
// Bench for shift_left_seq_unit: directed cases plus randomized operations,
// checked against a closed-form model of what N shifts produce.
module tb_shift_left_seq_unit;
    import shift_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   x;
    logic         cin;
    logic         sel1;
    logic         sel0;
    logic [2:0]   count;
    logic [7:0]   f;
    logic         cout;
    logic         busy;
    logic         done;
    state_t       state;

    int errors = 0;
    int checks = 0;

    shift_left_seq_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .cin   (cin),
        .sel1  (sel1),
        .sel0  (sel0),
        .count (count),
        .f     (f),
        .cout  (cout),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of n left shifts of x (with carry c) as {cout, f}, in closed form.
    function automatic logic [8:0] model(input logic [7:0] xv, input logic c,
                                         input logic [1:0] m, input int n);
        logic [7:0] r;
        logic       co;
        logic [8:0] v;
        if (n == 0) return {c, xv};
        r  = 8'h00;
        co = 1'b0;
        case (m)
            2'b00: begin
                r  = xv << n;
                co = xv[8-n];
            end
            2'b01: begin
                r  = (xv << n) | (xv >> (8 - n));
                co = r[0];
            end
            2'b10: begin
                v = {c, xv};
                v = (v << n) | (v >> (9 - n));
                return v;
            end
            default: begin
                r  = (xv << n) | (xv[0] ? 8'((1 << n) - 1) : 8'h00);
                co = xv[8-n];
            end
        endcase
        return {co, r};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: one full operation, checking every intermediate cycle.
    // poke=1 forces a start with x=FF mid-flight; otherwise inputs are scrambled randomly.
    task automatic run_op(input string tag, input logic [7:0] xv, input logic c,
                          input logic [1:0] m, input int n, input bit poke);
        logic [8:0] e;
        @(negedge clk);
        x = xv; cin = c; {sel1, sel0} = m; count = 3'(n); start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            e = model(xv, c, m, i);
            check({tag, ".busy"}, 16'(busy), 16'(1));
            check({tag, ".done_in_shift"}, 16'(done), 16'(0));
            check({tag, ".f_step"}, 16'(f), 16'(e[7:0]));
            check({tag, ".cout_step"}, 16'(cout), 16'(e[8]));
            if (poke) begin
                x = 8'hFF; start = 1'b1; count = 3'd7; cin = 1'b1; {sel1, sel0} = 2'b00;
            end else begin
                x = 8'($urandom); start = 1'($urandom_range(0, 1));
                count = 3'($urandom_range(0, 7)); cin = 1'($urandom_range(0, 1));
                {sel1, sel0} = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
        end
        e = model(xv, c, m, n);
        check({tag, ".done"}, 16'(done), 16'(1));
        check({tag, ".busy_in_done"}, 16'(busy), 16'(0));
        check({tag, ".state_done"}, 16'(state), 16'(DONE));
        check({tag, ".f"}, 16'(f), 16'(e[7:0]));
        check({tag, ".cout"}, 16'(cout), 16'(e[8]));
        x = 8'($urandom); start = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, ".done_once"}, 16'(done), 16'(0));
        check({tag, ".busy_idle"}, 16'(busy), 16'(0));
        check({tag, ".state_idle"}, 16'(state), 16'(IDLE));
        check({tag, ".f_hold"}, 16'(f), 16'(e[7:0]));
        check({tag, ".cout_hold"}, 16'(cout), 16'(e[8]));
        start = 1'b0;
    endtask

    // Directed sequence, then random operations
    initial begin
        rst = 1'b1; start = 1'b0; x = 8'h00; cin = 1'b0; sel1 = 1'b0; sel0 = 1'b0; count = 3'd0;
        #1;
        check("reset.f", 16'(f), 16'(0));
        check("reset.cout", 16'(cout), 16'(0));
        check("reset.busy", 16'(busy), 16'(0));
        check("reset.done", 16'(done), 16'(0));
        check("reset.state", 16'(state), 16'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hard-coded expectations from the worked examples
        run_op("logic1", 8'b10000001, 1'b0, 2'b00, 1, 1'b0);
        check("logic1.f_const", 16'(f), 16'(8'b00000010));
        check("logic1.cout_const", 16'(cout), 16'(1));
        run_op("rot3", 8'b10010110, 1'b0, 2'b01, 3, 1'b0);
        check("rot3.f_const", 16'(f), 16'(8'b10110100));
        check("rot3.cout_const", 16'(cout), 16'(0));
        run_op("carry2", 8'b11000000, 1'b1, 2'b10, 2, 1'b0);
        check("carry2.f_const", 16'(f), 16'(8'b00000011));
        check("carry2.cout_const", 16'(cout), 16'(1));
        run_op("fill4", 8'b00000011, 1'b0, 2'b11, 4, 1'b1);
        check("fill4.f_const", 16'(f), 16'(8'b00111111));
        check("fill4.cout_const", 16'(cout), 16'(0));
        run_op("zero", 8'hA5, 1'b1, 2'b00, 0, 1'b0);
        check("zero.f_const", 16'(f), 16'(8'hA5));
        check("zero.cout_const", 16'(cout), 16'(1));
        run_op("max7", 8'h5A, 1'b1, 2'b10, 7, 1'b0);

        // Asynchronous reset mid-SHIFT, between clock edges
        @(negedge clk);
        x = 8'hC3; cin = 1'b1; {sel1, sel0} = 2'b01; count = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rstmid.busy_before", 16'(busy), 16'(1));
        #2 rst = 1'b1;
        #1;
        check("rstmid.f", 16'(f), 16'(0));
        check("rstmid.cout", 16'(cout), 16'(0));
        check("rstmid.busy", 16'(busy), 16'(0));
        check("rstmid.done", 16'(done), 16'(0));
        check("rstmid.state", 16'(state), 16'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 8'b10010110, 1'b0, 2'b01, 3, 1'b0);

        // Randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            run_op("rand", 8'($urandom), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_left_seq_unit.md
SHIFT_LEFT_SEQ_UNIT -- requirements
Module: shift_left_seq_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data width in bits; all verification values assume WIDTH=8.
REQ-002 SHALL provide port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL provide port start, input, 1: request a new shift operation; sampled only in IDLE.
REQ-005 SHALL provide port x, input, WIDTH: operand loaded on an accepted start.
REQ-006 SHALL provide port cin, input, 1: carry-in loaded on an accepted start.
REQ-007 SHALL provide ports sel1 and sel0, input, 1 each: mode select {sel1,sel0}, latched on an accepted start.
REQ-008 SHALL provide port count, input, 3: number of single-bit left shifts (0-7), latched on an accepted start.
REQ-009 SHALL provide port f, output, WIDTH: shift register contents / result.
REQ-010 SHALL provide port cout, output, 1: carry register, holding the last bit shifted out.
REQ-011 SHALL provide port busy, output, 1: high while in SHIFT.
REQ-012 SHALL provide port done, output, 1: one-cycle pulse while in DONE.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL, at the sampling edge: load f<=x, cout<=cin, latch mode and count, and go to SHIFT (count>0) or DONE (count=0).
REQ-015 Each edge in SHIFT SHALL perform exactly one left shift: f<=f<<1 with the fill bit set by mode, cout<=old f[WIDTH-1], and the remaining count decremented.
REQ-016 Mode 00 SHALL be logical shift: fill 0.
REQ-017 Mode 01 SHALL be rotate: fill = old f[WIDTH-1].
REQ-018 Mode 10 SHALL be shift through carry: fill = old cout.
REQ-019 Mode 11 SHALL be lsb-replicate: fill = old f[0].
REQ-020 SHIFT SHALL go to DONE on the edge that performs the last shift (remaining count = 1).
REQ-021 Latency: for start sampled at edge k with count=N, done SHALL be high in the cycle following edge k+N, for every N from 0 to 7.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-023 f and cout SHALL hold their values in DONE and IDLE until the next accepted start.
REQ-024 start in SHIFT or DONE SHALL be ignored with no effect on state, f, cout or the latched mode and count.
REQ-025 x, cin, sel and count changes after acceptance SHALL NOT affect the operation in flight.
REQ-026 busy and done SHALL never be high together.
REQ-027 count=0 SHALL produce f=x and cout=cin with busy never asserted.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, f=0, cout=0, busy=0, done=0 and clear the latched mode and count, including mid-SHIFT.
REQ-029 After rst deasserts, the first accepted start SHALL behave identically to one issued after power-up.

Structure
REQ-030 Package shift_pkg SHALL hold the mode encodings (SHL_LOGIC=00, SHL_ROT=01, SHL_CARRY=10, SHL_FILL=11), the FSM state type and the count width constant (3).
REQ-031 One combinational sub-module, shift_left_step, SHALL compute a single-bit shift (inputs: value, carry, mode; outputs: shifted value, carry-out) and be instantiated once.

Verification
REQ-032 x=10000001, mode 00, count=1 -> f=00000010, cout=1, done one cycle after the start edge, busy high for 1 cycle.
REQ-033 x=10010110, mode 01, count=3 -> f=10110100, cout=0, busy high 3 cycles, then a single done pulse.
REQ-034 x=11000000, cin=1, mode 10, count=2 -> after step 1 f=10000001, cout=1; final f=00000011, cout=1.
REQ-035 x=00000011, mode 11, count=4 -> f=00111111, cout=0; a start pulsed mid-SHIFT with x=FF is ignored.
REQ-036 x=A5, cin=1, count=0 -> f=10100101, cout=1, done in the next cycle, busy never high.
REQ-037 rst asserted between clock edges during SHIFT -> f=0, cout=0, busy=0, done=0 immediately; state=IDLE, and a subsequent start completes correctly.
